// File: rtl/uart_wb_sequencer.sv
// Wishbone master that configures the UART and then services a TX byte stream
// and drains the RX FIFO, alternating TX-side and RX-side bus slots.
module uart_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MDW       = 9,
    parameter int          FAW       = 4,
    parameter int          ACK_TO    = 15
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [15:0]     cfg_prescaler_i,
    input  logic [31:0]     cfg_word_i,
    input  logic [MDW-1:0]  tx_data_i,
    input  logic            tx_valid_i,
    output logic            tx_ready_o,
    output logic [MDW-1:0]  rx_data_o,
    output logic            rx_valid_o,
    input  logic            rx_ready_i,
    output logic            cfg_done_o,
    output logic            err_o,
    output logic [31:0]     wbm_adr_o,
    output logic [31:0]     wbm_dat_o,
    input  logic [31:0]     wbm_dat_i,
    output logic [3:0]      wbm_sel_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    input  logic            wbm_ack_i
);

    localparam int          CW         = $clog2(ACK_TO + 1);
    localparam logic [31:0] OFF_RXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0004;
    localparam logic [31:0] OFF_PR     = 32'h0000_0008;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_000C;
    localparam logic [31:0] OFF_CFG    = 32'h0000_0010;
    localparam logic [31:0] OFF_RXLVL  = 32'h0000_FE00;
    localparam logic [31:0] OFF_TXLVL  = 32'h0000_FE10;

    typedef enum logic [3:0] {
        S_IDLE, S_PR, S_CFG, S_CTRL, S_TXPOLL, S_TXWR, S_RXPOLL, S_RXRD, S_STOP
    } state_t;

    state_t          state_q, state_d, nxt_s;
    logic            wait_q, wait_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            stop_pend_q, stop_pend_d;
    logic            run_s, stop_req_s;
    logic [FAW-1:0]  lvl_q;
    logic [MDW-1:0]  rx_data_q;
    logic            rx_valid_q;
    logic [31:0]     adr_q, adr_d, dat_q, dat_d;
    logic            stb_q, stb_d, we_q, we_d, tx_ready_q, tx_ready_d, cfg_done_q, cfg_done_d;
    logic            unused_dat_s;

    assign unused_dat_s = ^wbm_dat_i[31:MDW];

    // State register: one access is a STROBE cycle (wait_q=0) followed by WAIT (wait_q=1)
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            wait_q      <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next-state logic: stop requests are only honoured at an access boundary
    always_comb begin
        run_s       = (state_q == S_TXPOLL) || (state_q == S_TXWR) ||
                      (state_q == S_RXPOLL) || (state_q == S_RXRD);
        stop_req_s  = stop_pend_q | stop_i;
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        stop_pend_d = stop_pend_q | (run_s & stop_i);
        case (state_q)
            S_PR:     nxt_s = S_CFG;
            S_CFG:    nxt_s = S_CTRL;
            S_CTRL:   nxt_s = S_TXPOLL;
            S_TXPOLL: nxt_s = stop_req_s ? S_STOP :
                              (tx_valid_i && (lvl_q != {FAW{1'b1}})) ? S_TXWR : S_RXPOLL;
            S_TXWR:   nxt_s = stop_req_s ? S_STOP : S_RXPOLL;
            S_RXPOLL: nxt_s = stop_req_s ? S_STOP :
                              ((lvl_q != {FAW{1'b0}}) && !rx_valid_q) ? S_RXRD : S_TXPOLL;
            S_RXRD:   nxt_s = stop_req_s ? S_STOP : S_TXPOLL;
            default:  nxt_s = S_IDLE;
        endcase
        if (state_q == S_IDLE) begin
            if (start_i) begin
                state_d     = S_PR;
                wait_d      = 1'b0;
                err_d       = 1'b0;
                stop_pend_d = 1'b0;
            end else begin
                state_d     = S_IDLE;
            end
        end else if (!wait_q) begin
            wait_d = 1'b1;
            cnt_d  = {CW{1'b0}};
        end else if (wbm_ack_i) begin
            wait_d  = 1'b0;
            state_d = nxt_s;
            if ((nxt_s == S_STOP) || (nxt_s == S_IDLE)) begin
                stop_pend_d = 1'b0;
            end else begin
                stop_pend_d = stop_pend_d;
            end
        end else if (cnt_q == CW'(ACK_TO - 1)) begin
            err_d       = 1'b1;
            state_d     = S_IDLE;
            wait_d      = 1'b0;
            stop_pend_d = 1'b0;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        stb_d      = (state_d != S_IDLE) && !wait_d;
        cfg_done_d = (state_d == S_TXPOLL) || (state_d == S_TXWR) ||
                     (state_d == S_RXPOLL) || (state_d == S_RXRD);
        adr_d      = 32'h0000_0000;
        dat_d      = 32'h0000_0000;
        we_d       = 1'b0;
        tx_ready_d = 1'b0;
        if (stb_d) begin
            case (state_d)
                S_PR:     begin adr_d = BASE_ADDR | OFF_PR;     we_d = 1'b1; dat_d = {16'h0000, cfg_prescaler_i}; end
                S_CFG:    begin adr_d = BASE_ADDR | OFF_CFG;    we_d = 1'b1; dat_d = cfg_word_i; end
                S_CTRL:   begin adr_d = BASE_ADDR | OFF_CTRL;   we_d = 1'b1; dat_d = 32'h0000_0007; end
                S_STOP:   begin adr_d = BASE_ADDR | OFF_CTRL;   we_d = 1'b1; dat_d = 32'h0000_0000; end
                S_TXPOLL: begin adr_d = BASE_ADDR | OFF_TXLVL; end
                S_TXWR:   begin adr_d = BASE_ADDR | OFF_TXDATA; we_d = 1'b1; tx_ready_d = 1'b1;
                                dat_d = {{(32-MDW){1'b0}}, tx_data_i}; end
                S_RXPOLL: begin adr_d = BASE_ADDR | OFF_RXLVL; end
                S_RXRD:   begin adr_d = BASE_ADDR | OFF_RXDATA; end
                default:  begin adr_d = 32'h0000_0000; end
            endcase
        end else begin
            adr_d = 32'h0000_0000;
        end
    end

    // Registered bus and status outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            adr_q <= 32'h0000_0000; dat_q <= 32'h0000_0000;
            stb_q <= 1'b0; we_q <= 1'b0; tx_ready_q <= 1'b0; cfg_done_q <= 1'b0;
        end else begin
            adr_q <= adr_d; dat_q <= dat_d;
            stb_q <= stb_d; we_q <= we_d; tx_ready_q <= tx_ready_d; cfg_done_q <= cfg_done_d;
        end
    end

    // Read-data capture at the end of each strobe, and the RX output holding register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lvl_q      <= {FAW{1'b0}};
            rx_data_q  <= {MDW{1'b0}};
            rx_valid_q <= 1'b0;
        end else begin
            if ((state_q != S_IDLE) && !wait_q) begin
                lvl_q <= wbm_dat_i[FAW-1:0];
            end
            if ((state_q == S_RXRD) && !wait_q) begin
                rx_data_q  <= wbm_dat_i[MDW-1:0];
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_sel_o  = 4'hF;
    assign wbm_cyc_o  = stb_q;
    assign wbm_stb_o  = stb_q;
    assign wbm_we_o   = we_q;
    assign tx_ready_o = tx_ready_q;
    assign cfg_done_o = cfg_done_q;
    assign err_o      = err_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Directed bench for uart_wb_sequencer: a UART slave stand-in, a per-cycle
// behavioural reference, and hand-computed checkpoints for each scenario.
module tb_uart_wb_sequencer;

    localparam logic [31:0] BASE       = 32'h3000_0000;
    localparam logic [31:0] OFF_RXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0004;
    localparam logic [31:0] OFF_PR     = 32'h0000_0008;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_000C;
    localparam logic [31:0] OFF_CFG    = 32'h0000_0010;
    localparam logic [31:0] OFF_RXLVL  = 32'h0000_FE00;
    localparam logic [31:0] OFF_TXLVL  = 32'h0000_FE10;
    localparam logic [31:0] A_RXDATA = BASE | OFF_RXDATA, A_TXDATA = BASE | OFF_TXDATA;
    localparam logic [31:0] A_PR = BASE | OFF_PR, A_CTRL = BASE | OFF_CTRL, A_CFG = BASE | OFF_CFG;
    localparam logic [31:0] A_RXLVL = BASE | OFF_RXLVL, A_TXLVL = BASE | OFF_TXLVL;
    localparam int ACK_TO = 15;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, tx_valid, tx_ready, rx_valid, rx_ready, cfg_done, err;
    logic [15:0] pr;
    logic [31:0] cw, adr, dat_o, dat_i;
    logic [8:0]  tx_data, rx_data;
    logic [3:0]  sel;
    logic        cyc, stb, we, ack;

    // slave stand-in state
    logic        drop_cfg;
    logic [3:0]  tx_lvl;
    int          rx_fill, rx_ptr;
    logic [8:0]  rx_mem [0:7];
    logic [31:0] lg_adr [0:255];
    logic [31:0] lg_dat [0:255];
    int          lg_n, txr_cnt;

    int total = 0, bad = 0;
    logic chk_en = 1'b0;

    uart_wb_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
        .cfg_prescaler_i(pr), .cfg_word_i(cw),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .cfg_done_o(cfg_done), .err_o(err),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_sel_o(sel),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    // Slave: zero-wait ack, level registers with junk upper bits, RX pop on every RXDATA strobe
    always @(posedge clk) begin
        ack     <= stb && !(drop_cfg && (adr == A_CFG));
        txr_cnt <= txr_cnt + (tx_ready ? 1 : 0);
        if (stb && !we && (adr == A_RXDATA)) rx_ptr <= rx_ptr + 1;
        if (stb && (lg_n < 256)) begin
            lg_adr[lg_n] <= adr;
            lg_dat[lg_n] <= dat_o;
            lg_n         <= lg_n + 1;
        end
    end

    always_comb begin
        int lv;
        lv = rx_fill - rx_ptr;
        case (adr)
            A_TXLVL:  dat_i = 32'hFFFF_FFF0 | {28'h0, tx_lvl};
            A_RXLVL:  dat_i = 32'hFFFF_FFF0 | (lv & 32'hF);
            A_RXDATA: dat_i = {23'h7F_FFFF, rx_mem[rx_ptr[2:0]]};
            default:  dat_i = 32'h0;
        endcase
    end

    // Reference: mode 0 idle, 1 configuring, 2 running, 3 stopping; side/data pick the RUN slot
    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  cfg_idx;
        logic        side;
        logic        data;
        logic        strobe;
        logic        in_wait;
        logic [4:0]  waited;
        logic        err;
        logic        stop_pend;
        logic        rxv;
        logic [8:0]  rxd;
        logic [3:0]  lvl;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        txr;
    } model_t;

    model_t m;

    function automatic model_t launch(input model_t n, input logic [31:0] off,
                                      input logic w, input logic [31:0] d);
        model_t r;
        r = n;
        r.strobe = 1'b1; r.in_wait = 1'b0;
        r.adr = BASE | off; r.we = w; r.dat = d;
        r.txr = (off == OFF_TXDATA);
        return r;
    endfunction

    function automatic model_t step(input model_t q, input logic rn, input logic st, input logic sp,
                                    input logic txv, input logic [8:0] txd, input logic rxr,
                                    input logic ak, input logic [31:0] di,
                                    input logic [15:0] p, input logic [31:0] c);
        model_t n;
        n = q;
        n.strobe = 1'b0; n.txr = 1'b0; n.adr = 32'h0; n.dat = 32'h0; n.we = 1'b0;
        if (!rn) return '0;
        if (q.rxv && rxr) n.rxv = 1'b0;
        if (q.mode == 2'd2 && sp) n.stop_pend = 1'b1;
        if (q.mode == 2'd0) begin
            if (st) begin
                n.err = 1'b0; n.mode = 2'd1; n.cfg_idx = 2'd0; n.stop_pend = 1'b0;
                n = launch(n, OFF_PR, 1'b1, {16'h0, p});
            end
        end else if (q.strobe) begin
            n.in_wait = 1'b1; n.waited = 5'd0; n.lvl = di[3:0];
            if (q.adr == A_RXDATA && !q.we) begin n.rxd = di[8:0]; n.rxv = 1'b1; end
        end else if (ak) begin
            n.in_wait = 1'b0;
            if (q.mode == 2'd1) begin
                if (q.cfg_idx == 2'd0)      begin n.cfg_idx = 2'd1; n = launch(n, OFF_CFG, 1'b1, c); end
                else if (q.cfg_idx == 2'd1) begin n.cfg_idx = 2'd2; n = launch(n, OFF_CTRL, 1'b1, 32'h7); end
                else begin n.mode = 2'd2; n.side = 1'b0; n.data = 1'b0; n = launch(n, OFF_TXLVL, 1'b0, 32'h0); end
            end else if (q.mode == 2'd3) begin
                n.mode = 2'd0;
            end else if (q.stop_pend || sp) begin
                n.mode = 2'd3; n.stop_pend = 1'b0; n = launch(n, OFF_CTRL, 1'b1, 32'h0);
            end else if (!q.side && !q.data && txv && q.lvl < 4'd15) begin
                n.data = 1'b1; n = launch(n, OFF_TXDATA, 1'b1, {23'h0, txd});
            end else if (!q.side) begin
                n.side = 1'b1; n.data = 1'b0; n = launch(n, OFF_RXLVL, 1'b0, 32'h0);
            end else if (!q.data && q.lvl != 4'd0 && !q.rxv) begin
                n.data = 1'b1; n = launch(n, OFF_RXDATA, 1'b0, 32'h0);
            end else begin
                n.side = 1'b0; n.data = 1'b0; n = launch(n, OFF_TXLVL, 1'b0, 32'h0);
            end
        end else if (q.waited == 5'(ACK_TO - 1)) begin
            n.err = 1'b1; n.mode = 2'd0; n.in_wait = 1'b0; n.stop_pend = 1'b0;
        end else begin
            n.waited = q.waited + 5'd1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst_n, start, stop, tx_valid, tx_data, rx_ready, ack, dat_i, pr, cw);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cyc", {31'h0, cyc}, {31'h0, m.strobe});
            check("m_stb", {31'h0, stb}, {31'h0, m.strobe});
            check("m_we", {31'h0, we}, {31'h0, m.we});
            check("m_adr", adr, m.adr);
            check("m_dat", dat_o, m.dat);
            check("m_sel", {28'h0, sel}, 32'hF);
            check("m_txr", {31'h0, tx_ready}, {31'h0, m.txr});
            check("m_done", {31'h0, cfg_done}, {31'h0, (m.mode == 2'd2)});
            check("m_err", {31'h0, err}, {31'h0, m.err});
            check("m_rxv", {31'h0, rx_valid}, {31'h0, m.rxv});
            check("m_rxd", {23'h0, rx_data}, {23'h0, m.rxd});
        end
    end

    task automatic wait_strobe(input logic [31:0] a, input string nm);
        int k;
        k = 0;
        while (!(stb && adr == a) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(nm, {31'h0, (stb && adr == a)}, 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, c0, nt, k;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tx_valid = 1'b0; tx_data = 9'h0;
        rx_ready = 1'b0; pr = 16'h0020; cw = 32'h0000_0008; drop_cfg = 1'b0;
        tx_lvl = 4'd3; rx_fill = 0; rx_ptr = 0; lg_n = 0; txr_cnt = 0;
        for (int i = 0; i < 8; i++) rx_mem[i] = 9'h0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_cyc", {31'h0, cyc}, 32'h0);
        check("rst_sel", {28'h0, sel}, 32'hF);
        check("rst_rxd", {23'h0, rx_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bring-up
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pr_stb", {31'h0, stb}, 32'h1);
        check("pr_adr", adr, 32'h3000_0008);
        repeat (5) @(negedge clk);
        check("done_c6", {31'h0, cfg_done}, 32'h0);
        @(negedge clk);
        check("done_c7", {31'h0, cfg_done}, 32'h1);
        check("txlvl_c7", adr, 32'h3000_FE10);
        check("cfg_nwr", lg_n, 32'd3);
        check("wr0_adr", lg_adr[0], 32'h3000_0008); check("wr0_dat", lg_dat[0], 32'h20);
        check("wr1_adr", lg_adr[1], 32'h3000_0010); check("wr1_dat", lg_dat[1], 32'h8);
        check("wr2_adr", lg_adr[2], 32'h3000_000C); check("wr2_dat", lg_dat[2], 32'h7);

        // TX stream of three words
        b0 = lg_n;
        for (int i = 0; i < 3; i++) begin
            tx_data = 9'(32'h41 + i);
            tx_valid = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!tx_ready && k < 100);
            check("tx_go", {31'h0, tx_ready}, 32'h1);
        end
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        nt = 0;
        for (int j = b0; j < lg_n; j++) begin
            if (lg_adr[j] == A_TXDATA) begin
                check("txd_val", lg_dat[j], 32'h41 + nt);
                check("tx_then_rx", lg_adr[j+1], 32'h3000_FE00);
                nt++;
            end
        end
        check("tx_count", nt, 32'd3);
        check("txr_cnt", txr_cnt, 32'd3);

        // TX FIFO full: no writes
        tx_lvl = 4'd15;
        repeat (10) @(negedge clk);
        tx_valid = 1'b1; tx_data = 9'h044;
        b0 = lg_n; c0 = txr_cnt;
        repeat (40) @(negedge clk);
        nt = 0;
        for (int j = b0; j < lg_n; j++) if (lg_adr[j] == A_TXDATA) nt++;
        check("full_nowr", nt, 32'd0);
        check("full_txr", txr_cnt - c0, 32'd0);
        tx_valid = 1'b0;
        @(negedge clk);
        tx_lvl = 4'd3;

        // RX drain with backpressure
        rx_mem[rx_ptr[2:0]] = 9'h155;
        rx_mem[3'(rx_ptr + 1)] = 9'h0AA;
        rx_fill = rx_ptr + 2;
        b0 = lg_n;
        repeat (40) @(negedge clk);
        check("rx1_v", {31'h0, rx_valid}, 32'h1);
        check("rx1_d", {23'h0, rx_data}, 32'h155);
        nt = 0;
        for (int j = b0; j < lg_n; j++) if (lg_adr[j] == A_RXDATA) nt++;
        check("rx1_reads", nt, 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        k = 0;
        while (!(rx_valid && rx_data == 9'h0AA) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rx2_d", {23'h0, rx_data}, 32'h0AA);
        nt = 0;
        for (int j = b0; j < lg_n; j++) if (lg_adr[j] == A_RXDATA) nt++;
        check("rx2_reads", nt, 32'd2);
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rx_drained", {31'h0, rx_valid}, 32'h0);

        // Stop while a TX level poll is waiting
        @(negedge clk);
        wait_strobe(A_TXLVL, "stop_poll");
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_adr", adr, 32'h3000_000C);
        check("stop_dat", dat_o, 32'h0);
        check("stop_done", {31'h0, cfg_done}, 32'h0);
        repeat (3) @(negedge clk);
        check("stop_prev", lg_adr[lg_n-2], 32'h3000_FE10);
        check("stop_last", lg_adr[lg_n-1], 32'h3000_000C);
        b0 = lg_n;
        repeat (20) @(negedge clk);
        check("stop_quiet", lg_n - b0, 32'd0);

        // Ack timeout on the CFG write
        drop_cfg = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe(A_CFG, "to_cfg");
        repeat (15) @(negedge clk);
        check("to_err15", {31'h0, err}, 32'h0);
        @(negedge clk);
        check("to_err16", {31'h0, err}, 32'h1);
        b0 = lg_n;
        repeat (10) @(negedge clk);
        check("to_idle", lg_n - b0, 32'd0);
        drop_cfg = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_clear", {31'h0, err}, 32'h0);
        repeat (12) @(negedge clk);

        // Reset during a TXDATA strobe
        tx_data = 9'h055; tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rm_txr", {31'h0, tx_ready}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rm_cyc", {31'h0, cyc}, 32'h0);
        check("rm_txr0", {31'h0, tx_ready}, 32'h0);
        check("rm_done", {31'h0, cfg_done}, 32'h0);
        check("rm_adr", adr, 32'h0);
        rst_n = 1'b1; tx_valid = 1'b0;
        b0 = lg_n;
        repeat (20) @(negedge clk);
        check("rm_quiet", lg_n - b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
